fifo_uart_tx: RTL and testbench

- Read-side consumer for the team's 8-deep synchronous byte FIFO.
- Pops one byte whenever the FIFO is non-empty and the block is idle, then serializes it as an 8N1 UART frame on `tx`.
- Sits between the FIFO read port (`empty`/`read_en`/`read_data`, show-ahead: `read_data` = head entry whenever not empty) and the board TX pin.

---
 rtl/fifo_uart_tx_if.sv | 10 +
 rtl/fifo_uart_tx.sv | 123 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the show-ahead byte FIFO and its UART consumer.
// master = consumer (issues pops), slave = FIFO (presents head byte and empty flag).
interface fifo_uart_tx_if;
   logic       fifo_empty;
   logic [7:0] fifo_read_data;
   logic       fifo_read_en;

   modport master (input fifo_empty, input fifo_read_data, output fifo_read_en);
   modport slave  (output fifo_empty, output fifo_read_data, input fifo_read_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and serializes them as 8N1 UART frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int              CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t          r_state,    w_state_nxt;
   logic [CW-1:0]   r_baud_cnt, w_baud_nxt;
   logic [2:0]      r_bit_idx,  w_bit_nxt;
   logic [7:0]      r_shift,    w_shift_nxt;
   logic            r_tx,       w_tx_nxt;
   logic            r_read_en,  w_read_en_nxt;
   logic            r_done,     w_done_nxt;
   logic            w_bit_end;

   assign w_bit_end         = (r_baud_cnt == BAUD_LAST);
   assign tx                = r_tx;
   assign busy              = (r_state != S_IDLE);
   assign frame_done        = r_done;
   assign fifo.fifo_read_en = r_read_en;

   // NOTE: every target gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud_cnt;
      w_bit_nxt     = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_read_en_nxt = 1'b0;
      w_done_nxt    = 1'b0;

      if (r_state != S_IDLE) begin
         w_baud_nxt = w_bit_end ? '0 : r_baud_cnt + CW'(1);
      end

      unique case (r_state)
         S_IDLE: begin
            if (enable && !fifo.fifo_empty) begin
               w_shift_nxt   = fifo.fifo_read_data;
               w_read_en_nxt = 1'b1;
               w_baud_nxt    = '0;
               w_state_nxt   = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_bit_nxt   = 3'd0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_bit_nxt = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // tx is registered, so it is derived from where the FSM is heading next
      unique case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_tx_nxt = ^w_shift_nxt;
`endif
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'h00;
         r_tx       <= 1'b1;
         r_read_en  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_read_en  <= w_read_en_nxt;
         r_done     <= w_done_nxt;
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, a line
// monitor decodes tx frames and compares them with bytes queued at stimulus time.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic tx, busy, frame_done;

   fifo_uart_tx_if u_if ();

   fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo       (u_if),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          n_pops   = 0;
   int          n_pushed = 0;
   logic [7:0]  fifo_q[$];
   logic [7:0]  exp_q[$];
   int          starts[$];

   bit          m_act = 1'b0;
   bit          m_bad;
   int          m_idx;
   logic [10:0] m_bits;

   always @(posedge clk) cyc++;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
      n_pushed++;
   endtask

   task automatic frame_check();
      logic [7:0] got;
      logic [7:0] exp;
      got = m_bits[8:1];
      if (busy !== 1'b0) m_bad = 1'b1;
      check(!m_bad && m_bits[0] == 1'b0 && m_bits[NB-1] == 1'b1, "frame_shape", m_bits, 0);
      check(frame_done === 1'b1, "frame_done_at_end", frame_done, 1);
      check(exp_q.size() != 0, "expected_avail", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         check(got == exp, "rx_byte", got, exp);
`ifdef UART_TX_PARITY_EN
         check(m_bits[9] == ^exp, "parity_bit", m_bits[9], ^exp);
`endif
      end
   endtask

   // FIFO model plus tx-line monitor, all evaluated on the falling edge
   initial begin
      u_if.fifo_empty     = 1'b1;
      u_if.fifo_read_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_act = 1'b0;
         end else begin
            if (!m_act && tx === 1'b0) begin
               m_act  = 1'b1;
               m_idx  = 0;
               m_bad  = 1'b0;
               m_bits = '0;
               starts.push_back(cyc);
            end
            if (u_if.fifo_read_en === 1'b1) begin
               n_pops++;
               check(m_act && m_idx == 0, "pop_in_first_start", m_idx, 0);
               check(fifo_q.size() != 0, "pop_nonempty", fifo_q.size(), 1);
               if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (m_act) begin
               if (m_idx < FRAME) begin
                  if (m_idx % CPB == 0) m_bits[m_idx / CPB] = tx;
                  else if (tx !== m_bits[m_idx / CPB]) m_bad = 1'b1;
                  if (busy !== 1'b1 || frame_done !== 1'b0) m_bad = 1'b1;
                  m_idx++;
               end else begin
                  frame_check();
                  m_act = 1'b0;
               end
            end
         end
         u_if.fifo_empty     = (fifo_q.size() == 0);
         u_if.fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
      end
   end

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || m_act || busy !== 1'b0) && n < max) begin
         @(negedge clk);
         n++;
      end
      check(n < max, name, n, max);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  p0, s0, n;
      bit  bad;

      // reset held with a byte waiting
      enable = 1'b1;
      push(8'hA5);
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk); #1;
         if (tx !== 1'b1 || u_if.fifo_read_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad = 1'b1;
      end
      check(!bad, "reset_hold", bad, 0);

      // single byte after release
      p0 = n_pops; s0 = starts.size();
      @(negedge clk); #1 reset = 1'b1;
      wait_idle(3 * FRAME, "t2_timeout");
      check(n_pops - p0 == 1, "t2_pops", n_pops - p0, 1);
      check(starts.size() - s0 == 1, "t2_frames", starts.size() - s0, 1);

      // three back-to-back bytes
      p0 = n_pops;
      push(8'h00); push(8'hFF); push(8'h3C);
      wait_idle(5 * FRAME, "t3_timeout");
      check(n_pops - p0 == 3, "t3_pops", n_pops - p0, 3);
      n = starts.size();
      check(starts[n-1] - starts[n-2] == FRAME + 1, "t3_spacing_b", starts[n-1] - starts[n-2], FRAME + 1);
      check(starts[n-2] - starts[n-3] == FRAME + 1, "t3_spacing_a", starts[n-2] - starts[n-3], FRAME + 1);

      // asynchronous reset mid-frame
      push(8'h55); push(8'hC3);
      n = 0;
      while (!m_act && n < 20) begin @(negedge clk); n++; end
      check(n < 20, "t4_start_timeout", n, 20);
      repeat (13) @(negedge clk);
      #1 reset = 1'b0;
      #1 check(tx === 1'b1 && busy === 1'b0, "t4_async_reset", {tx, busy}, 2);
      p0 = n_pops; bad = 1'b0;
      repeat (10) begin
         @(negedge clk); #1;
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      check(!bad, "t4_reset_idle", bad, 0);
      check(n_pops == p0, "t4_no_pop_in_reset", n_pops - p0, 0);
      void'(exp_q.pop_front());
      s0 = starts.size();
      #1 reset = 1'b1;
      wait_idle(3 * FRAME, "t4_timeout");
      check(n_pops - p0 == 1, "t4_fresh_pop", n_pops - p0, 1);
      check(starts.size() - s0 == 1, "t4_fresh_frame", starts.size() - s0, 1);

      // enable gating
      enable = 1'b0;
      push(8'h9A); push(8'h4E);
      p0 = n_pops; bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b1 || u_if.fifo_read_en !== 1'b0) bad = 1'b1;
      end
      check(!bad && n_pops == p0, "t5_disabled_quiet", n_pops - p0, 0);
      #1 enable = 1'b1;
      @(negedge clk);
      check(u_if.fifo_read_en === 1'b1 && tx === 1'b0, "t5_enable_start", {u_if.fifo_read_en, tx}, 2);
      repeat (2 * CPB + 2) @(negedge clk);
      enable = 1'b0;
      repeat (FRAME + 20) @(negedge clk);
      check(n_pops - p0 == 1, "t5_drop_pops", n_pops - p0, 1);
      check(busy === 1'b0 && exp_q.size() == 1, "t5_drop_idle", exp_q.size(), 1);
      enable = 1'b1;
      wait_idle(3 * FRAME, "t5_timeout");
      check(n_pops - p0 == 2, "t5_resume_pops", n_pops - p0, 2);

`ifdef UART_TX_PARITY_EN
      push(8'h07); push(8'h03);
      wait_idle(4 * FRAME, "t6_timeout");
`endif

      // randomized bursts with occasional enable gaps
      for (int b = 0; b < 15; b++) begin
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) push(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
            enable = 1'b1;
         end
         repeat ($urandom_range(0, 60)) @(negedge clk);
      end
      wait_idle(50 * FRAME, "rand_timeout");
      check(n_pops == n_pushed, "total_pops", n_pops, n_pushed);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
